// File: rtl/lut3_table_capture.sv
// Truth-table characteriser for a 3-input function block: sweeps the select code 0..7,
// samples the 1-bit response after a settle time and compares the table with a reference.
module lut3_table_capture #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] expected_i,
    output logic [2:0] probe_sel_o,
    input  logic       probe_in_i,
    output logic [7:0] table_out_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       match_o
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [3:0] SettleReload = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    state_e     state_q;
    logic [3:0] cnt_q;
    logic [2:0] sel_q;
    logic [7:0] table_q;
    logic       busy_q;
    logic       done_q;
    logic       match_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            sel_q   <= 3'd0;
            table_q <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                // Partial table is kept for debug; everything else returns to idle.
                state_q <= StIdle;
                cnt_q   <= 4'd0;
                sel_q   <= 3'd0;
                busy_q  <= 1'b0;
                match_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        sel_q <= 3'd0;
                        if (start_i) begin
                            state_q <= StSettle;
                            cnt_q   <= SettleReload;
                            table_q <= 8'd0;
                            match_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                    StSettle: begin
                        if (cnt_q == 4'd0) begin
                            state_q <= StSample;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                    StSample: begin
                        table_q[sel_q] <= probe_in_i;
                        if (sel_q == 3'd7) begin
                            state_q <= StDone;
                            sel_q   <= 3'd0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StSettle;
                            sel_q   <= sel_q + 3'd1;
                            cnt_q   <= SettleReload;
                        end
                    end
                    StDone: begin
                        // A start here begins a fresh sweep and wins over the compare.
                        if (start_i) begin
                            state_q <= StSettle;
                            cnt_q   <= SettleReload;
                            table_q <= 8'd0;
                            match_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            match_q <= (table_q == expected_i);
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        sel_q   <= 3'd0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign probe_sel_o = sel_q;
    assign table_out_o = table_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign match_o     = match_q;

endmodule

// File: tb/tb_lut3_table_capture.sv
// Directed bench for lut3_table_capture: default settle time (dut_a) and settle time 1 (dut_b).
module tb_lut3_table_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start_a = 1'b0, abort_a = 1'b0;
    logic [7:0] expected_a = 8'h00, f_a = 8'h00;
    logic [2:0] sel_a;
    logic       in_a;
    logic [7:0] table_a;
    logic       busy_a, done_a, match_a;

    logic       start_b = 1'b0, abort_b = 1'b0;
    logic [7:0] expected_b = 8'h00, f_b = 8'h00;
    logic [2:0] sel_b;
    logic       in_b = 1'b0;
    logic [7:0] table_b;
    logic       busy_b, done_b, match_b;
    logic       prev_busy_b = 1'b0;
    logic [2:0] prev_sel_b = 3'd0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign in_a = f_a[sel_a];

    // Drive the wrong response during the first cycle of every code on dut_b.
    always @(negedge clk) begin
        if (busy_b && (!prev_busy_b || sel_b != prev_sel_b)) in_b = ~f_b[sel_b];
        else in_b = f_b[sel_b];
        prev_busy_b = busy_b;
        prev_sel_b  = sel_b;
    end

    lut3_table_capture dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .abort_i(abort_a),
        .expected_i(expected_a), .probe_sel_o(sel_a), .probe_in_i(in_a),
        .table_out_o(table_a), .busy_o(busy_a), .done_o(done_a), .match_o(match_a)
    );

    lut3_table_capture #(.SETTLE_CYCLES(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .abort_i(abort_b),
        .expected_i(expected_b), .probe_sel_o(sel_b), .probe_in_i(in_b),
        .table_out_o(table_b), .busy_o(busy_b), .done_o(done_b), .match_o(match_b)
    );

    // Start a sweep on dut_a, optionally re-pulse start at cycle restart_at, observe 60 cycles.
    task automatic run_a(input logic [7:0] func, input int restart_at,
                         output int first_done, output int ndone);
        int n;
        @(negedge clk);
        f_a = func;
        start_a = 1'b1;
        n = 0;
        first_done = 0;
        ndone = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            n++;
            start_a = (n == restart_at);
            if (done_a) begin
                ndone++;
                if (first_done == 0) first_done = n;
            end
        end
        start_a = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        total++; if (sel_a !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel_a); end
        total++; if (table_a !== 8'h00) begin bad++; $display("FAIL reset_table got=%h exp=00", table_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_a); end
        total++; if (match_a !== 1'b0) begin bad++; $display("FAIL reset_match got=%b exp=0", match_a); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_median;
        int fd, nd;
        expected_a = 8'hE8;
        run_a(8'hE8, 0, fd, nd);
        total++; if (fd !== 25) begin bad++; $display("FAIL median_latency got=%0d exp=25", fd); end
        total++; if (nd !== 1) begin bad++; $display("FAIL median_done_count got=%0d exp=1", nd); end
        total++; if (table_a !== 8'hE8) begin bad++; $display("FAIL median_table got=%h exp=e8", table_a); end
        total++; if (match_a !== 1'b1) begin bad++; $display("FAIL median_match got=%b exp=1", match_a); end
    endtask

    task automatic test_xor;
        int fd, nd;
        expected_a = 8'hE8;
        run_a(8'h96, 0, fd, nd);
        total++; if (fd !== 25) begin bad++; $display("FAIL xor_latency got=%0d exp=25", fd); end
        total++; if (nd !== 1) begin bad++; $display("FAIL xor_done_count got=%0d exp=1", nd); end
        total++; if (table_a !== 8'h96) begin bad++; $display("FAIL xor_table got=%h exp=96", table_a); end
        total++; if (match_a !== 1'b0) begin bad++; $display("FAIL xor_match got=%b exp=0", match_a); end
    endtask

    task automatic test_restart_ignored;
        int fd, nd;
        expected_a = 8'h3C;
        run_a(8'h3C, 10, fd, nd);
        total++; if (fd !== 25) begin bad++; $display("FAIL restart_latency got=%0d exp=25", fd); end
        total++; if (nd !== 1) begin bad++; $display("FAIL restart_done_count got=%0d exp=1", nd); end
        total++; if (table_a !== 8'h3C) begin bad++; $display("FAIL restart_table got=%h exp=3c", table_a); end
        total++; if (match_a !== 1'b1) begin bad++; $display("FAIL restart_match got=%b exp=1", match_a); end
    endtask

    task automatic test_back_to_back;
        int n;
        bit seen;
        expected_a = 8'hA5;
        @(negedge clk);
        f_a = 8'hA5;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        seen = 1'b0;
        for (n = 1; n < 40 && !seen; n++) begin
            if (done_a) seen = 1'b1;
            else @(negedge clk);
        end
        total++; if (!seen) begin bad++; $display("FAIL b2b_done_timeout got=none exp=pulse"); end
        total++; if (table_a !== 8'hA5) begin bad++; $display("FAIL b2b_first_table got=%h exp=a5", table_a); end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy_a); end
        total++; if (table_a !== 8'h00) begin bad++; $display("FAIL b2b_table_clear got=%h exp=00", table_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL b2b_done got=%b exp=0", done_a); end
        repeat (30) @(negedge clk);
        total++; if (match_a !== 1'b1) begin bad++; $display("FAIL b2b_second_match got=%b exp=1", match_a); end
    endtask

    task automatic test_abort;
        bit seen;
        int nd;
        expected_a = 8'hFF;
        @(negedge clk);
        f_a = 8'hFF;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (sel_a == 3'd3) seen = 1'b1;
            else @(negedge clk);
        end
        total++; if (!seen) begin bad++; $display("FAIL abort_reach_code3 got=none exp=sel3"); end
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy_a); end
        total++; if (sel_a !== 3'd0) begin bad++; $display("FAIL abort_sel got=%0d exp=0", sel_a); end
        total++; if (match_a !== 1'b0) begin bad++; $display("FAIL abort_match got=%b exp=0", match_a); end
        total++; if (table_a !== 8'h07) begin bad++; $display("FAIL abort_table got=%h exp=07", table_a); end
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            if (done_a) nd++;
            @(negedge clk);
        end
        total++; if (nd !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", nd); end
        abort_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        start_a = 1'b0;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL abort_start_busy got=%b exp=0", busy_a); end
        @(negedge clk);
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL abort_start_idle got=%b exp=0", busy_a); end
    endtask

    task automatic test_settle1;
        int n;
        bit seen;
        expected_b = 8'h5A;
        @(negedge clk);
        f_b = 8'h5A;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        seen = 1'b0;
        for (n = 1; n <= 40 && !seen; n++) begin
            if (done_b) begin
                seen = 1'b1;
                total++; if (n !== 17) begin bad++; $display("FAIL s1_latency got=%0d exp=17", n); end
            end else begin
                if (n <= 16) begin
                    total++;
                    if (sel_b !== 3'((n - 1) / 2)) begin
                        bad++; $display("FAIL s1_sel_cycle%0d got=%0d exp=%0d", n, sel_b, (n - 1) / 2);
                    end
                end
                @(negedge clk);
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL s1_done_timeout got=none exp=pulse"); end
        total++; if (table_b !== 8'h5A) begin bad++; $display("FAIL s1_table got=%h exp=5a", table_b); end
        @(negedge clk);
        total++; if (match_b !== 1'b1) begin bad++; $display("FAIL s1_match got=%b exp=1", match_b); end
    endtask

    task automatic test_reset_mid;
        int nb;
        @(negedge clk);
        f_a = 8'hFF;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (7) @(negedge clk);
        total++; if (table_a !== 8'h03) begin bad++; $display("FAIL rstmid_pre_table got=%h exp=03", table_a); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (table_a !== 8'h00) begin bad++; $display("FAIL rstmid_table got=%h exp=00", table_a); end
        total++; if (sel_a !== 3'd0) begin bad++; $display("FAIL rstmid_sel got=%0d exp=0", sel_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy_a); end
        total++; if (match_a !== 1'b0) begin bad++; $display("FAIL rstmid_match got=%b exp=0", match_a); end
        @(negedge clk);
        #2 rst_n = 1'b1;
        nb = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy_a || done_a) nb++;
        end
        total++; if (nb !== 0) begin bad++; $display("FAIL rstmid_stays_idle got=%0d exp=0", nb); end
    endtask

    initial begin
        test_reset;
        test_median;
        test_xor;
        test_restart_ignored;
        test_back_to_back;
        test_abort;
        test_settle1;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
